// File: rtl/cp0_exc_if.sv
// Pipeline-side bundle for the CP0 exception unit: mfc0/mtc0 access, victim
// information from MEM, interrupt pins, and the flush/redirect response.
interface cp0_exc_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD_in;
  logic [4:0]  ExcCode_in;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] HandlerPC;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A1, A2, DIn, WE, PC, BD_in, ExcCode_in, HWInt, EXLClr,
    input  IntReq, HandlerPC, EPC, DOut
  );

  modport slave (
    input  A1, A2, DIn, WE, PC, BD_in, ExcCode_in, HWInt, EXLClr,
    output IntReq, HandlerPC, EPC, DOut
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception/interrupt responder: decides when to trap, saves
// EPC/Cause/BD, tracks EXL, and serves mfc0/mtc0/eret.
module cp0_exc_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_4150,
  parameter logic [31:0] EXC_ADDR   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  cp0_exc_if.slave    bus
);

  typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} exl_state_e;

  exl_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [29:0] epc_q, epc_d;

  logic        exl_s;
  logic        int_pend_s;
  logic        exc_pend_s;
  logic        int_req_s;
  logic        wr_sr_s;
  logic        wr_epc_s;
  logic [31:0] victim_pc_s;
  logic [31:0] dout_s;

  // Trap request: interrupts use the live pins, and nothing is accepted while EXL is set.
  always_comb begin
    exl_s       = (state_q == HANDLER);
    int_pend_s  = (|(bus.HWInt & im_q)) & ie_q & ~exl_s;
    exc_pend_s  = (bus.ExcCode_in != 5'd0) & ~exl_s;
    int_req_s   = int_pend_s | exc_pend_s;
    wr_sr_s     = bus.WE & ~int_req_s & (bus.A2 == 5'd12);
    wr_epc_s    = bus.WE & ~int_req_s & (bus.A2 == 5'd14);
    victim_pc_s = bus.BD_in ? (bus.PC - 32'd4) : bus.PC;
  end

  // Next-state: EXL machine, trap capture, mtc0 writes (dropped when trapping).
  always_comb begin
    state_d = state_q;
    im_d    = im_q;
    ie_d    = ie_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    ip_d    = bus.HWInt;

    case (state_q)
      NORMAL: begin
        if (int_req_s) begin
          state_d = HANDLER;
        end else begin
          state_d = NORMAL;
        end
      end
      HANDLER: begin
        if (bus.EXLClr) begin
          state_d = NORMAL;
        end else begin
          state_d = HANDLER;
        end
      end
      default: state_d = NORMAL;
    endcase

    if (int_req_s) begin
      exc_d = int_pend_s ? 5'd0 : bus.ExcCode_in;
      bd_d  = bus.BD_in;
      epc_d = victim_pc_s[31:2];
    end else begin
      if (wr_sr_s) begin
        im_d    = bus.DIn[15:10];
        ie_d    = bus.DIn[0];
        state_d = bus.DIn[1] ? HANDLER : NORMAL;
      end else begin
        im_d = im_q;
      end
      if (wr_epc_s) begin
        epc_d = bus.DIn[31:2];
      end else begin
        epc_d = epc_q;
      end
      // eret overrides an mtc0 to SR for the EXL bit only.
      if (bus.EXLClr) begin
        state_d = NORMAL;
      end else begin
        state_d = state_d;
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      im_q    <= 6'd0;
      ie_q    <= 1'b0;
      bd_q    <= 1'b0;
      ip_q    <= 6'd0;
      exc_q   <= 5'd0;
      epc_q   <= 30'd0;
    end else begin
      state_q <= state_d;
      im_q    <= im_d;
      ie_q    <= ie_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read mux; unmapped register numbers read as zero.
  always_comb begin
    dout_s = 32'd0;
    case (bus.A1)
      5'd12:   dout_s = {16'd0, im_q, 8'd0, exl_s, ie_q};
      5'd13:   dout_s = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
      5'd14:   dout_s = {epc_q, 2'd0};
      5'd15:   dout_s = PRID_VALUE;
      default: dout_s = 32'd0;
    endcase
  end

  assign bus.IntReq    = int_req_s;
  assign bus.HandlerPC = EXC_ADDR;
  assign bus.EPC       = {epc_q, 2'd0};
  assign bus.DOut      = dout_s;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: stimulus pushes expected reads into a
// scoreboard queue, an independent monitor pops and compares them.
module tb_cp0_exc_unit;

  logic clk;
  logic reset;

  cp0_exc_if bus();

  cp0_exc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  a1;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops each expectation and compares once the read address has settled.
  initial begin
    exp_t it;
    forever begin
      wait (sb_q.size() > 0);
      #1;
      it = sb_q.pop_front();
      cmp({it.name, ".dout"}, bus.DOut, it.dout);
      cmp({it.name, ".intreq"}, {31'd0, bus.IntReq}, {31'd0, it.irq});
      cmp({it.name, ".handlerpc"}, bus.HandlerPC, 32'h0000_4180);
      if (it.a1 == 5'd14) cmp({it.name, ".epc"}, bus.EPC, it.dout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] a1,
                     input logic [31:0] dout, input logic irq);
    exp_t it;
    bus.A1 = a1;
    it.name = nm;
    it.a1   = a1;
    it.dout = dout;
    it.irq  = irq;
    sb_q.push_back(it);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0;
    bus.PC = 32'd0; bus.BD_in = 1'b0; bus.ExcCode_in = 5'd0;
    bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // 1: reset state
    chk("rst_sr",   5'd12, 32'h0000_0000, 1'b0);
    chk("rst_cause",5'd13, 32'h0000_0000, 1'b0);
    chk("rst_epc",  5'd14, 32'h0000_0000, 1'b0);
    chk("rst_prid", 5'd15, 32'h0000_4150, 1'b0);
    tick();
    chk("unmapped", 5'd5,  32'h0000_0000, 1'b0);

    // 2: RI exception, not in delay slot
    bus.ExcCode_in = 5'd10; bus.PC = 32'h0000_3010; bus.BD_in = 1'b0;
    chk("ri_req", 5'd12, 32'h0000_0000, 1'b1);
    tick();
    chk("ri_cause", 5'd13, 32'h0000_0028, 1'b0);
    chk("ri_epc",   5'd14, 32'h0000_3010, 1'b0);
    chk("ri_sr",    5'd12, 32'h0000_0002, 1'b0);

    // 3: enable IM[10]/IE, then interrupt beats a concurrent exception
    bus.ExcCode_in = 5'd0;
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    bus.WE = 1'b0;
    chk("sr_wr", 5'd12, 32'h0000_0401, 1'b0);
    bus.HWInt = 6'b000001; bus.ExcCode_in = 5'd4; bus.BD_in = 1'b1; bus.PC = 32'h0000_3020;
    chk("int_req",    5'd12, 32'h0000_0401, 1'b1);
    chk("ip_lag",     5'd13, 32'h0000_0028, 1'b1);
    tick();
    chk("int_cause",  5'd13, 32'h8000_0400, 1'b0);
    chk("int_epc_bd", 5'd14, 32'h0000_301C, 1'b0);
    chk("int_sr",     5'd12, 32'h0000_0403, 1'b0);

    // 4: eret with interrupt still pending re-requests
    bus.ExcCode_in = 5'd0; bus.BD_in = 1'b0; bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0; bus.PC = 32'h0000_3040;
    chk("eret_rereq", 5'd12, 32'h0000_0401, 1'b1);
    tick();
    chk("retake_cause", 5'd13, 32'h0000_0400, 1'b0);
    chk("retake_epc",   5'd14, 32'h0000_3040, 1'b0);
    bus.HWInt = 6'd0;

    // 5: mtc0 EPC accepted, then discarded under a concurrent exception
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3007;
    tick();
    bus.WE = 1'b0;
    chk("epc_wr", 5'd14, 32'h0000_3004, 1'b0);
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    chk("eret_sr", 5'd12, 32'h0000_0401, 1'b0);
    bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h5555_5555;
    bus.ExcCode_in = 5'd12; bus.PC = 32'h0000_3050;
    chk("ov_req", 5'd14, 32'h0000_3004, 1'b1);
    tick();
    bus.WE = 1'b0; bus.ExcCode_in = 5'd0;
    chk("epc_drop",  5'd14, 32'h0000_3050, 1'b0);
    chk("ov_cause",  5'd13, 32'h0000_0030, 1'b0);

    // PC wrap in a delay slot
    bus.EXLClr = 1'b1;
    tick();
    bus.EXLClr = 1'b0;
    bus.ExcCode_in = 5'd8; bus.BD_in = 1'b1; bus.PC = 32'h0000_0000;
    tick();
    bus.ExcCode_in = 5'd0; bus.BD_in = 1'b0;
    chk("wrap_epc",   5'd14, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_cause", 5'd13, 32'h8000_0020, 1'b0);

    // Cause is read-only to mtc0
    bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    bus.WE = 1'b0;
    chk("cause_ro", 5'd13, 32'h8000_0020, 1'b0);

    // eret and mtc0 SR on the same edge: EXL cleared, IM/IE written
    bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0802; bus.EXLClr = 1'b1;
    tick();
    bus.WE = 1'b0; bus.EXLClr = 1'b0;
    chk("eret_vs_mtc0", 5'd12, 32'h0000_0800, 1'b0);

    // 6: reset while in handler with a concurrent exception
    bus.ExcCode_in = 5'd10; bus.PC = 32'h0000_3100;
    tick();
    chk("pre_rst_sr", 5'd12, 32'h0000_0802, 1'b0);
    reset = 1'b1;
    tick();
    bus.ExcCode_in = 5'd0;
    reset = 1'b0;
    chk("rst2_sr",    5'd12, 32'h0000_0000, 1'b0);
    chk("rst2_cause", 5'd13, 32'h0000_0000, 1'b0);
    chk("rst2_epc",   5'd14, 32'h0000_0000, 1'b0);

    #5;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
